// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins plus decoded key outputs of the scanner.
interface keypad_scanner_if;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  modport master (input cols, output rows, key, key_valid, key_held);
  modport slave (output cols, input rows, key, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad row scan with sweep-level debounce.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic clk,
  input logic reset,
  keypad_scanner_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;
  state_t state;
  logic [DW-1:0] dwell;
  logic [3:0] sync1, sync2, hit, cand, cnt, code, acc_code, run_n, rel_n;
  logic [2:0] row_n, tot_raw;
  logic [1:0] row_idx, acc_n, col_c, tot;
  logic sample, sweep_done, single, none, go_cand;
  // acc_n saturates at 2 so a sweep only distinguishes none, one or many keys
  always_comb begin
    hit = ~sync2;
    row_n = {2'b0, hit[0]} + {2'b0, hit[1]} + {2'b0, hit[2]} + {2'b0, hit[3]};
    col_c = hit[0] ? 2'd0 : hit[1] ? 2'd1 : hit[2] ? 2'd2 : 2'd3;
    tot_raw = {1'b0, acc_n} + row_n;
    tot = tot_raw > 3'd1 ? 2'd2 : tot_raw[1:0];
    code = row_n == 3'd1 ? {row_idx, col_c} : acc_code;
    sample = dwell == LAST;
    sweep_done = sample && row_idx == 2'd3;
    single = tot == 2'd1;
    none = tot == 2'd0;
    go_cand = single && (state == IDLE || state == PRESS_WAIT || code != kp.key);
    run_n = (state == PRESS_WAIT && code == cand) ? cnt + {3'b0, cnt != 4'd15} : 4'd1;
    rel_n = state == REL_WAIT ? cnt + {3'b0, cnt != 4'd15} : 4'd1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
      dwell <= '0;
      row_idx <= 2'd0;
      acc_n <= 2'd0;
      acc_code <= 4'd0;
      state <= IDLE;
      cand <= 4'd0;
      cnt <= 4'd0;
      kp.rows <= 4'b1110;
      kp.key <= 4'd0;
      kp.key_valid <= 1'b0;
      kp.key_held <= 1'b0;
    end else begin
      sync1 <= kp.cols;
      sync2 <= sync1;
      kp.key_valid <= 1'b0;
      if (sample) begin
        dwell <= '0;
        row_idx <= row_idx + 2'd1;
        kp.rows <= ~(4'b0001 << (row_idx + 2'd1));
        acc_n <= sweep_done ? 2'd0 : tot;
        acc_code <= sweep_done ? 4'd0 : code;
      end else
        dwell <= dwell + DW'(1);
      if (sweep_done) begin
        if (go_cand) begin
          if (run_n >= DEB) begin
            state <= HELD;
            cnt <= 4'd0;
            kp.key <= code;
            kp.key_valid <= 1'b1;
            kp.key_held <= 1'b1;
          end else begin
            state <= PRESS_WAIT;
            cand <= code;
            cnt <= run_n;
            kp.key_held <= 1'b0;
          end
        end else if (state == HELD || state == REL_WAIT) begin
          // roll-over (MULTI) and a bounce back to the held key both keep it held
          if (none && rel_n >= DEB) begin
            state <= IDLE;
            cnt <= 4'd0;
            kp.key_held <= 1'b0;
          end else begin
            state <= none ? REL_WAIT : HELD;
            cnt <= none ? rel_n : 4'd0;
          end
        end else begin
          state <= IDLE;
          cnt <= 4'd0;
        end
      end
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad and turns debounced key presses into a 4-bit key code with a one-cycle valid strobe. It is the input-side counterpart to the board's display output path: the display driver turns a 4-bit value into pins, and this block turns pins back into a 4-bit value. It sits in `top` beside the display driver. Its `key` output feeds the value registers in place of raw switch inputs.

## Interface
Parameters:
- SCAN_DIV, 1000: clock cycles each row is driven (dwell). Legal values are 4 or more.
- DEBOUNCE_SCANS, 4: consecutive identical full sweeps required to accept a press or a release. Legal range is 1 to 15.

Ports:
- clk  input  1: system clock, rising-edge.
- reset  input  1: asynchronous reset, active-low.
- cols  input  4: keypad column lines. Active-low, with pull-ups on the board; asynchronous to clk.
- rows  output  4: keypad row drive. Active-low one-hot, so exactly one bit is 0 at all times.
- key  output  4: code of the last accepted key, equal to 4*row + col.
- key_valid  output  1: one-cycle pulse when a new key is accepted.
- key_held  output  1: high while an accepted key remains stably pressed.

## Operation
- **Synchroniser:** `cols` passes through a 2-flop synchroniser before any use.
- **Row scan:**
  - A dwell counter counts 0 to SCAN_DIV-1 and then wraps.
  - On the wrap, the row index advances 0→1→2→3→0.
  - rows = ~(4'b0001 << row_idx).
- **Column sampling:**
  - The synchronised columns are sampled when dwell == SCAN_DIV-1. By that point at least 2 cycles have passed since the row change, so the synchroniser output reflects the driven row.
  - A column reading 0 means the key at (row_idx, col) is pressed.
- **Sweep result:** evaluated at the row-3 sample. Over the whole sweep:
  - zero pressed keys → NONE.
  - exactly one pressed key → SINGLE(code).
  - two or more pressed keys → MULTI.
- **Debounce state machine:** states are IDLE, PRESS_WAIT, HELD and REL_WAIT. The candidate code and a saturating counter are held with the state.
  - IDLE: SINGLE(c) → PRESS_WAIT with candidate = c and count = 1. NONE or MULTI → stay in IDLE.
  - PRESS_WAIT, on SINGLE(c):
    - If c equals the candidate, count increments.
    - If c differs, candidate = c and count = 1.
    - When count reaches DEBOUNCE_SCANS, go to HELD: key = candidate, key_valid pulses, key_held = 1.
  - PRESS_WAIT, on NONE or MULTI: back to IDLE, count = 0.
  - HELD:
    - SINGLE(key) → stay in HELD.
    - NONE → REL_WAIT with count = 1.
    - MULTI → stay in HELD with no change. A roll-over does not release the key.
    - SINGLE(c≠key) → PRESS_WAIT with candidate = c and count = 1. key_held drops to 0; key is unchanged.
  - REL_WAIT:
    - NONE → count increments. At DEBOUNCE_SCANS, go to IDLE with key_held = 0.
    - SINGLE(key) → back to HELD, bounce ignored.
    - SINGLE(c≠key) → PRESS_WAIT with candidate = c, key_held = 0.
    - MULTI → back to HELD.
- **DEBOUNCE_SCANS = 1:** the state machine goes from IDLE straight to HELD on the first SINGLE, and from HELD straight to IDLE on the first NONE.
- **Re-press:** pressing the same key again after a full release produces a new key_valid pulse.
- **Reset values (asynchronous, reset low):**
  - rows = 4'b1110, key = 0, key_valid = 0, key_held = 0.
  - State IDLE, all counters 0, synchroniser flops = 4'b1111.
- **Reset mid-sweep:** all scan and debounce progress is discarded. A sweep restarts at row 0 on the first clk edge after reset goes high.

## Timing
- One sweep lasts 4*SCAN_DIV cycles.
- **Press latency:**
  - key_valid rises exactly 1 cycle after the row-3 sample of the sweep that completes debounce.
  - Measured from a press that is stable before a sweep starts, that is DEBOUNCE_SCANS sweeps plus 1 cycle.
  - The worst case from an arbitrary press instant is (DEBOUNCE_SCANS+1) sweeps plus 1 cycle.
- **Registered outputs:** key and key_held change in the same cycle that key_valid is high.
- **key_valid width:** never high for two consecutive cycles.
- **rows timing:** rows is registered and changes on the cycle after the dwell wrap.
- **Outputs:** all outputs come from flops; none is a combinational function of `cols`.

## Test plan
Bench parameters: SCAN_DIV = 4, DEBOUNCE_SCANS = 2, so one sweep is 16 cycles.

- **Reset and scan pattern:** assert reset low mid-sweep, then release. Required:
  - rows = 1110 during reset.
  - After release, rows cycles 1110→1101→1011→0111, 4 cycles per row.
  - key = 0, key_valid = 0, key_held = 0.
- **Single key press:** model key (row 2, col 1) pressed from sweep start. Required:
  - key_valid is a single pulse 33 cycles later, with key = 9.
  - key_held = 1 until release.
- **Release and re-press:** release the key for 2 sweeps, then press it again. Required:
  - key_held falls after the second NONE sweep.
  - The re-press gives a second key_valid pulse with key = 9.
- **Bounce rejection:** press key 5 and drop it for 1 sweep in every 2. Required: no key_valid pulse. While key 5 is HELD, a 1-sweep release does not drop key_held.
- **Multi-key:** hold keys 3 and 12 together from IDLE. Required: no key_valid pulse. Then release key 12. Required: key_valid with key = 3 after 2 sweeps.
- **Key change while held:** hold key 0 until accepted, then switch directly to key 15. Required:
  - key_held drops at the first sweep showing key 15.
  - key_valid pulses with key = 15 after the second such sweep.
